// File: rtl/iir_pkg.sv
// Shared types and constants for the time-shared 2nd-order IIR sequencer.
// State encoding, tap index type and the default coefficient set live here.
package iir_pkg;

    localparam int IIR_DATA_W = 32;

    // Default coefficients: y = B0*x0 + B1*x1 + B2*x2 - A1*y1 - A2*y2
    localparam int IIR_B0 = 6;
    localparam int IIR_B1 = 1;
    localparam int IIR_B2 = 2;
    localparam int IIR_A1 = 4;
    localparam int IIR_A2 = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef logic [2:0] tap_t;

    localparam tap_t LAST_TAP = 3'd4;

    // Taps 3 and 4 are the feedback terms and are subtracted from the accumulator.
    function automatic logic tap_is_feedback(input tap_t tap);
        return (tap >= 3'd3);
    endfunction

endpackage

// File: rtl/iir_mac_sched_if.sv
// Sample stream bus: x_in enters on a valid/ready pair, y_out leaves on another.
// A transfer happens on a rising edge where valid and ready are both high; the
// sender holds valid and data stable until that edge and never retracts valid.
interface iir_mac_sched_if #(
    parameter int DATA_W = iir_pkg::IIR_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] y_out;

    modport slave (
        input  in_valid,
        input  x_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y_out
    );

    modport master (
        output in_valid,
        output x_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y_out
    );
endinterface

// File: rtl/iir_mac.sv
// Single multiplier with a registered accumulator; one product folded in per enabled cycle.
// o_acc_nxt exposes the value the accumulator will take so the final sum is usable on its last edge.
module iir_mac #(
    parameter int DATA_W = iir_pkg::IIR_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_sub,
    input  logic [DATA_W-1:0] i_coef,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_acc_nxt
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_acc_nxt;

    // The low DATA_W bits of a product are identical for signed and unsigned
    // operands, so a DATA_W-wide multiply gives the truncated signed result.
    assign w_prod    = i_coef * i_data;
    assign w_acc_nxt = i_sub ? (r_acc - w_prod) : (r_acc + w_prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc     = r_acc;
    assign o_acc_nxt = w_acc_nxt;

endmodule

// File: rtl/iir_mac_sched.sv
// Direct-form-I biquad sequencer: accepts one sample, runs five taps through a
// shared multiplier, updates the x/y history and presents y_out until taken.
module iir_mac_sched
    import iir_pkg::*;
#(
    parameter int DATA_W = IIR_DATA_W,
    parameter int B0     = IIR_B0,
    parameter int B1     = IIR_B1,
    parameter int B2     = IIR_B2,
    parameter int A1     = IIR_A1,
    parameter int A2     = IIR_A2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    iir_mac_sched_if.slave        bus,
    output logic                  busy,
    output state_t                dbg_state
);

    state_t            r_state;
    state_t            w_state_nxt;
    tap_t              r_tap;
    logic [DATA_W-1:0] r_xc;
    logic [DATA_W-1:0] r_x1;
    logic [DATA_W-1:0] r_x2;
    logic [DATA_W-1:0] r_y1;
    logic [DATA_W-1:0] r_y2;
    logic [DATA_W-1:0] r_y_out;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_mac_en;
    logic              w_mac_last;
    logic              w_mac_clear;
    logic              w_sub;
    logic [DATA_W-1:0] w_coef;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_acc;
    logic [DATA_W-1:0] w_acc_nxt;

    // clr wins over the input handshake, so ready is withdrawn while it is high.
    assign bus.in_ready  = (r_state == S_IDLE) && !clr;
    assign bus.out_valid = r_out_valid;
    assign bus.y_out     = r_y_out;
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mac_en    = 1'b0;
        w_mac_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid && !clr) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                w_mac_en = 1'b1;
                if (r_tap == LAST_TAP) begin
                    w_mac_last  = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_mac_en    = 1'b0;
            w_mac_last  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand select: tap index picks one coefficient/history pair per cycle.
    always_comb begin
        w_coef = '0;
        w_data = '0;
        w_sub  = tap_is_feedback(r_tap);
        case (r_tap)
            3'd0: begin w_coef = DATA_W'(B0); w_data = r_xc; end
            3'd1: begin w_coef = DATA_W'(B1); w_data = r_x1; end
            3'd2: begin w_coef = DATA_W'(B2); w_data = r_x2; end
            3'd3: begin w_coef = DATA_W'(A1); w_data = r_y1; end
            3'd4: begin w_coef = DATA_W'(A2); w_data = r_y2; end
            default: begin w_coef = '0; w_data = '0; end
        endcase
    end

    assign w_mac_clear = clr || w_accept;

    iir_mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_mac_clear),
        .i_en      (w_mac_en),
        .i_sub     (w_sub),
        .i_coef    (w_coef),
        .i_data    (w_data),
        .o_acc     (w_acc),
        .o_acc_nxt (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap       <= '0;
            r_xc        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_y_out     <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_tap       <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_xc  <= bus.x_in;
                r_tap <= '0;
            end
            if (w_mac_en) begin
                r_tap <= r_tap + 3'd1;
            end
            // Final tap: publish the completed sum and shift it into the history.
            if (w_mac_last) begin
                r_tap       <= '0;
                r_y_out     <= w_acc_nxt;
                r_out_valid <= 1'b1;
                r_x2        <= r_x1;
                r_x1        <= r_xc;
                r_y2        <= r_y1;
                r_y1        <= w_acc_nxt;
            end
            if ((r_state == S_OUT) && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Registered accumulator is observed through o_acc_nxt on the last tap only.
    logic w_acc_unused;
    assign w_acc_unused = ^w_acc;

endmodule

// File: tb/tb_iir_mac_sched.sv
// Directed bench for iir_mac_sched: golden stream table plus hand-written
// sequences for latency, backpressure, clear, async reset and wrap-around.
module tb_iir_mac_sched;
    import iir_pkg::*;

    logic   clk;
    logic   reset;
    logic   clr;
    logic   busy;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    iir_mac_sched_if #(.DATA_W(32)) bus ();

    iir_mac_sched dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t stream_tbl[8];

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Always-on protocol invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.in_ready && bus.out_valid) begin
                errors++;
                $display("FAIL ready_valid_excl: got in_ready=1 out_valid=1 required not both");
            end
            if ($isunknown({bus.in_ready, bus.out_valid, bus.y_out, busy})) begin
                errors++;
                $display("FAIL no_x: got unknown on outputs required known values");
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] x);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles required 1");
        end
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL out_valid_timeout: got out_valid=0 for 50 cycles required 1");
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] exp, input string name);
        offer(x);
        wait_out();
        check(name, bus.y_out, exp);
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_stream(input string tag);
        for (int i = 0; i < 8; i++) begin
            send(stream_tbl[i].x, stream_tbl[i].y, $sformatf("%s_y%0d", tag, i));
        end
    endtask

    initial begin
        int seen;
        stream_tbl[0] = '{32'd1, 32'd6};
        stream_tbl[1] = '{32'd2, -32'sd11};
        stream_tbl[2] = '{32'd3, 32'd48};
        stream_tbl[3] = '{32'd4, -32'sd128};
        stream_tbl[4] = '{32'd5, 32'd408};
        stream_tbl[5] = '{32'd6, -32'sd1199};
        stream_tbl[6] = '{32'd7, 32'd3630};
        stream_tbl[7] = '{32'd8, -32'sd10856};

        reset         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_y_out", bus.y_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        #11 reset = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1) golden stream
        run_stream("stream");

        // 2) latency: accept at edge k, out_valid after edge k+5
        do_clr();
        offer(32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("lat_in_ready_e%0d", i), {31'd0, bus.in_ready}, 32'd0);
            check($sformatf("lat_out_valid_e%0d", i), {31'd0, bus.out_valid}, (i == 6) ? 32'd1 : 32'd0);
        end
        check("lat_y", bus.y_out, 32'd6);
        tick();
        check("lat_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        check("lat_consumed", {31'd0, bus.out_valid}, 32'd0);

        // 3) backpressure
        do_clr();
        bus.out_ready = 1'b0;
        offer(32'd1);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp_y_%0d", i), bus.y_out, 32'd6);
            check($sformatf("bp_ready_%0d", i), {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_released", {31'd0, bus.out_valid}, 32'd0);
        send(32'd2, -32'sd11, "bp_next");

        // 4) clr during tap 2 of x=3
        do_clr();
        send(32'd1, 32'd6, "clr_pre0");
        send(32'd2, -32'sd11, "clr_pre1");
        offer(32'd3);
        tick();
        tick();
        check("clr_in_tap2", {29'd0, dut.r_tap}, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("clr_no_output", seen, 32'd0);
        tick();
        send(32'd1, 32'd6, "clr_after");

        // clr with in_valid in the same cycle: input must not be taken
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in     = 32'd5;
        #1;
        check("clr_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_no_accept", {31'd0, busy}, 32'd0);

        // 5) async reset mid-MAC
        offer(32'd9);
        tick();
        #2 reset = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_y_out", bus.y_out, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        #13 reset = 1'b1;
        tick();
        run_stream("restart");

        // 6) wrap-around
        do_clr();
        send(32'h7FFFFFFF, 32'hFFFFFFFA, "wrap_y0");
        send(32'h7FFFFFFF, 32'h80000011, "wrap_y1");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
